spi_controller: RTL and testbench
=================================

# spi_controller

Initiator side of the team's write-only SPI register link. Accepts one register write per valid/ready handshake and serialises it as a 16-bit SPI mode-0 frame on SCLK/nCS/COPI for the on-chip SPI register peripheral. Frame layout is MSB first: bit 15 = 1 (write), bits 14:8 = register address, bits 7:0 = data. The block sits in the test/bring-up path and drives the peripheral's ui_in SPI pins.

## Interface
Parameters:
- HALF_PERIOD, default 4: clk cycles per SCLK phase, high or low. Legal range ≥ 3, so the peripheral's 2-flop synchroniser sees every phase.
- GAP_CYCLES, default 4: minimum clk cycles nCS stays high between frames. Legal range ≥ 1.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  7  target register address.
- req_data  in  8  write data.
- busy  out  1  a frame or gap is in progress (inverse of req_ready).
- done  out  1  one-cycle pulse when nCS rises at frame end.
- err  out  1  one-cycle pulse for a rejected address. Tied 0 without the macro.
- sclk  out  1  SPI clock, idles low.
- ncs  out  1  SPI chip select, active low.
- copi  out  1  SPI serial data out.

## Operation
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP.
- Counters:
  - 4-bit bit index, counts 15 down to 0.
  - Phase counter, counts 0 to HALF_PERIOD-1.
- IDLE:
  - Outputs: req_ready=1, ncs=1, sclk=0, copi=0.
  - On req_valid & req_ready, latch shift reg = {1'b1, req_addr, req_data}.
  - Request inputs are sampled only at the handshake. Later changes are ignored.
- SETUP: ncs=0, copi=bit15, sclk=0 for HALF_PERIOD cycles, then go to SCLK_HI.
- SCLK_HI: sclk=1 for HALF_PERIOD cycles. The peripheral samples COPI on this rising edge.
  - Bit index 0 → HOLD.
  - Otherwise → SCLK_LO.
- SCLK_LO: sclk=0. On the first cycle of the phase, copi advances to the next lower bit. Holds HALF_PERIOD cycles, then go to SCLK_HI.
- HOLD: sclk=0, ncs=0, copi holds bit 0, for HALF_PERIOD cycles, then go to GAP.
- GAP:
  - ncs=1, copi=0, done=1 on the first GAP cycle only.
  - Holds GAP_CYCLES cycles, then go to IDLE.
- While not in IDLE: req_ready=0, and req_valid is ignored (no queuing).
- Reset, including mid-frame, immediately forces IDLE outputs: ncs=1, sclk=0, copi=0, req_ready=1, busy=0, done=0, err=0. The frame is abandoned. The peripheral commits on its nCS rising edge, so a truncated frame may still be committed there. This is an accepted hazard.

## Timing
- Handshake at rising edge T: ncs=0 and copi=bit15 from edge T+1.
- First sclk rise at T+1+HALF_PERIOD.
- Exactly 16 sclk rising edges per frame. COPI is stable ≥ HALF_PERIOD cycles before and after each rise.
- ncs is low for 2·HALF_PERIOD + 16·2·HALF_PERIOD − HALF_PERIOD = 33·HALF_PERIOD cycles. With defaults, 132 cycles.
- done is asserted at edge T+1+33·HALF_PERIOD.
- req_ready returns GAP_CYCLES cycles after that.
- Back-to-back throughput: one frame per 33·HALF_PERIOD + GAP_CYCLES + 1 cycles (137 with defaults).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SPI_CTRL_ADDR_CHECK_EN defined:
  - A handshake with req_addr > 7'h04 is accepted, but no frame is sent.
  - ncs stays 1 and done stays 0.
  - err pulses on edge T+1; req_ready is low for that one cycle, then high again.
  - Addresses 0x00–0x04 behave normally.
- Not defined: every address is transmitted unchanged, and err is constant 0.

## Test plan
- Addr 0x00, data 0xA5, defaults → 132-cycle ncs low window, 16 sclk rises, sampled bits 1000_0000_1010_0101, a single done pulse.
- Two requests with req_valid held high (addr 0x02/0x3C, then 0x03/0xC3) → second handshake exactly 137 cycles after the first, ncs high ≥ 4 cycles between frames, both frames bit-exact.
- req_addr/req_data changed to 0x7F/0xFF mid-frame, req_valid high → no effect on the current frame; the new request is taken only when req_ready returns.
- rst pulsed after the 6th sclk rise → next cycle ncs=1, sclk=0, req_ready=1. A new request afterwards produces a full clean frame.
- With SPI_CTRL_ADDR_CHECK_EN, addr 0x05 → err=1 for one cycle, ncs never low, done=0. Addr 0x04 still transmits normally.
- Loopback into the SPI register peripheral: write addr 0x04 data 0x80, then addr 0x01 data 0x0F → peripheral outputs pwm_duty_cycle=0x80 and en_reg_out[15:8]=0x0F.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: initiator for the write-only SPI register link.
// Each accepted request becomes one 16-bit SPI mode-0 frame, MSB first:
//   bit 15 = 1 (write), bits 14:8 = register address, bits 7:0 = data.
// Optional feature macro: SPI_CTRL_ADDR_CHECK_EN. When defined, requests
// whose address is above 7'h04 are accepted but dropped: no frame is sent
// and err pulses for one cycle. When undefined, every address is sent and
// err is tied to 0.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid and req_ready are both high. req_addr/req_data are sampled only
// on that edge. req_ready is high only while idle, so requests presented
// during a frame or the inter-frame gap wait (nothing is queued).
//
// Every output comes straight from a flop. The flops are loaded from the
// next-state decode, so outputs change on the same edge as the state.
module spi_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SCLK_HI = 3'd2,
    ST_SCLK_LO = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  // State and datapath registers
  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [GW-1:0] r_gap;
  logic [3:0]    r_bit;
  logic [15:0]   r_shift;

  // Output registers
  logic r_ready;
  logic r_busy;
  logic r_done;
  logic r_sclk;
  logic r_ncs;
  logic r_copi;

  // Next-state values
  state_t        w_state_nxt;
  logic [PW-1:0] w_phase_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic [3:0]    w_bit_nxt;
  logic [15:0]   w_shift_nxt;
  logic          w_done_nxt;
  logic          w_ready_nxt;
  logic          w_sclk_nxt;
  logic          w_ncs_nxt;
  logic          w_copi_nxt;
  logic          w_in_frame;

  logic w_hs;
  logic w_bad_addr;
  logic w_phase_last;
  logic w_gap_last;

  assign w_hs         = req_valid & r_ready;
  assign w_phase_last = (r_phase == PH_LAST);
  assign w_gap_last   = (r_gap == GAP_LAST);

`ifdef SPI_CTRL_ADDR_CHECK_EN
  // Only registers 0x00..0x04 exist in the peripheral.
  assign w_bad_addr = (req_addr > 7'h04);
`else
  assign w_bad_addr = 1'b0;
`endif

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_gap_nxt   = r_gap;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        w_gap_nxt   = '0;
        if (w_hs && !w_bad_addr) begin
          w_state_nxt = ST_SETUP;
          w_shift_nxt = {1'b1, req_addr, req_data};
          w_bit_nxt   = 4'd15;
        end
      end

      // nCS low with bit 15 on COPI before the first SCLK rise
      ST_SETUP: begin
        if (w_phase_last) begin
          w_state_nxt = ST_SCLK_HI;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end

      // Peripheral samples COPI on entry to this phase
      ST_SCLK_HI: begin
        if (w_phase_last) begin
          w_phase_nxt = '0;
          if (r_bit == 4'd0) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_SCLK_LO;
            w_bit_nxt   = r_bit - 4'd1;
            w_shift_nxt = {r_shift[14:0], 1'b0};
          end
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end

      // COPI moved to the next bit on entry; held for the whole low phase
      ST_SCLK_LO: begin
        if (w_phase_last) begin
          w_state_nxt = ST_SCLK_HI;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end

      // Keep bit 0 stable after the last rise before releasing nCS
      ST_HOLD: begin
        if (w_phase_last) begin
          w_state_nxt = ST_GAP;
          w_phase_nxt = '0;
          w_gap_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end

      // nCS high; the peripheral commits the frame on this rising edge
      ST_GAP: begin
        if (w_gap_last) begin
          w_state_nxt = ST_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
        w_gap_nxt   = '0;
      end
    endcase

    w_in_frame  = (w_state_nxt == ST_SETUP)   || (w_state_nxt == ST_SCLK_HI) ||
                  (w_state_nxt == ST_SCLK_LO) || (w_state_nxt == ST_HOLD);
    w_ncs_nxt   = ~w_in_frame;
    w_sclk_nxt  = (w_state_nxt == ST_SCLK_HI);
    w_copi_nxt  = w_in_frame & w_shift_nxt[15];
    // A dropped request still takes req_ready low for the cycle after it.
    w_ready_nxt = (w_state_nxt == ST_IDLE) && !(w_hs && w_bad_addr);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_gap   <= '0;
      r_bit   <= 4'd0;
      r_shift <= 16'h0000;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_ncs   <= 1'b1;
      r_copi  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_gap   <= w_gap_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
      r_done  <= w_done_nxt;
      r_sclk  <= w_sclk_nxt;
      r_ncs   <= w_ncs_nxt;
      r_copi  <= w_copi_nxt;
    end
  end

`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic r_err;

  // One-cycle pulse for each dropped out-of-range request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && w_hs && w_bad_addr;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sclk      = r_sclk;
  assign ncs       = r_ncs;
  assign copi      = r_copi;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller with default
// parameters (HALF_PERIOD=4, GAP_CYCLES=4). A negedge monitor rebuilds each
// frame from sclk/copi/ncs and acts as a small register-file peripheral.
module tb_spi_controller;

  localparam int HP        = 4;
  localparam int GAP       = 4;
  localparam int FRAME_LOW = 33 * HP;
  localparam int PERIOD    = 33 * HP + GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  spi_controller #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .dbg_state (dbg_state)
  );

  // Monitor / peripheral model state
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_ncs = 1'b1;
  logic        prev_copi = 1'b0;
  int          cur_rises = 0;
  int          cur_low = 0;
  int          fall_cyc = 0;
  int          first_rise_off = -1;
  int          last_rise_cyc = -1;
  logic [15:0] cur_bits = 16'h0000;
  logic [15:0] frame_q[$];
  logic [15:0] exp_q[$];
  int          low_q[$];
  int          rise_q[$];
  int          off_q[$];
  int          gap_q[$];
  int          hs_q[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          fall_cnt = 0;
  int          ready_low_cnt = 0;
  int          copi_viol = 0;
  int          done_miss = 0;
  logic [7:0]  regs [0:127];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (req_valid && req_ready) hs_q.push_back(cyc);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!req_ready) ready_low_cnt++;
      if (!ncs && prev_ncs) begin
        fall_cnt++;
        cur_rises = 0;
        cur_low = 0;
        cur_bits = 16'h0000;
        fall_cyc = cyc;
        first_rise_off = -1;
        if (last_rise_cyc >= 0) gap_q.push_back(cyc - last_rise_cyc);
      end
      if (!ncs) cur_low++;
      if (sclk && !prev_sclk) begin
        cur_rises++;
        cur_bits = {cur_bits[14:0], copi};
        if (cur_rises == 1) first_rise_off = cyc - fall_cyc;
      end
      if (sclk && prev_sclk && (copi !== prev_copi)) copi_viol++;
      if (ncs && !prev_ncs) begin
        frame_q.push_back(cur_bits);
        low_q.push_back(cur_low);
        rise_q.push_back(cur_rises);
        off_q.push_back(first_rise_off);
        last_rise_cyc = cyc;
        if (done !== 1'b1) done_miss++;
        if (cur_rises == 16 && cur_bits[15]) regs[cur_bits[14:8]] = cur_bits[7:0];
      end
    end
    prev_sclk = sclk;
    prev_ncs  = ncs;
    prev_copi = copi;
  end

  // Driver tasks
  task automatic clear_mon();
    frame_q.delete();
    exp_q.delete();
    low_q.delete();
    rise_q.delete();
    off_q.delete();
    gap_q.delete();
    hs_q.delete();
    done_cnt = 0;
    fall_cnt = 0;
    ready_low_cnt = 0;
    done_miss = 0;
    last_rise_cyc = -1;
  endtask

  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int k;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (k >= 400) $display("FAIL send_timeout: req_ready stayed %b, required 1", req_ready);
    else n_pass++;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frame_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (frame_q.size() < n) $display("FAIL frame_timeout: got %0d frames, required %0d", frame_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (ncs !== 1'b1) $display("FAIL reset_ncs: got %b, required 1", ncs); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b, required 0", sclk); else n_pass++;
    n_checks++; if (copi !== 1'b0) $display("FAIL reset_copi: got %b, required 0", copi); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b, required 0", err); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_mon();
    exp_q.push_back(16'h80A5);
    send(7'h00, 8'hA5);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL single_busy: got busy=%b ready=%b, required busy=1 ready=0", busy, req_ready); else n_pass++;
    wait_frames(1);
    wait_ready();
    n_checks++; if (frame_q[0] !== exp_q[0]) $display("FAIL single_bits: got %h, required %h", frame_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (rise_q[0] !== 16) $display("FAIL single_rises: got %0d, required 16", rise_q[0]); else n_pass++;
    n_checks++; if (low_q[0] !== FRAME_LOW) $display("FAIL single_ncs_low: got %0d, required %0d", low_q[0], FRAME_LOW); else n_pass++;
    n_checks++; if (off_q[0] !== HP) $display("FAIL single_first_rise: got %0d, required %0d", off_q[0], HP); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL single_done_count: got %0d, required 1", done_cnt); else n_pass++;
    n_checks++; if (done_miss !== 0) $display("FAIL single_done_align: got %0d misses, required 0", done_miss); else n_pass++;
    n_checks++; if (copi_viol !== 0) $display("FAIL single_copi_stable: got %0d changes, required 0", copi_viol); else n_pass++;
    n_checks++; if (ready_low_cnt !== FRAME_LOW + GAP) $display("FAIL single_ready_low: got %0d, required %0d", ready_low_cnt, FRAME_LOW + GAP); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    clear_mon();
    exp_q.push_back(16'h823C);
    exp_q.push_back(16'h83C3);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 7'h02;
    req_data  = 8'h3C;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_addr = 7'h03;
    req_data = 8'hC3;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_frames(2);
    wait_ready();
    n_checks++; if (hs_q.size() !== 2) $display("FAIL b2b_hs_count: got %0d, required 2", hs_q.size()); else n_pass++;
    n_checks++; if (hs_q[1] - hs_q[0] !== PERIOD) $display("FAIL b2b_period: got %0d, required %0d", hs_q[1] - hs_q[0], PERIOD); else n_pass++;
    n_checks++; if (frame_q[0] !== exp_q[0]) $display("FAIL b2b_bits0: got %h, required %h", frame_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (frame_q[1] !== exp_q[1]) $display("FAIL b2b_bits1: got %h, required %h", frame_q[1], exp_q[1]); else n_pass++;
    n_checks++; if (gap_q[0] < GAP) $display("FAIL b2b_gap: got %0d, required >= %0d", gap_q[0], GAP); else n_pass++;
    n_checks++; if (low_q[1] !== FRAME_LOW) $display("FAIL b2b_ncs_low1: got %0d, required %0d", low_q[1], FRAME_LOW); else n_pass++;
    n_checks++; if (rise_q[1] !== 16) $display("FAIL b2b_rises1: got %0d, required 16", rise_q[1]); else n_pass++;
    n_checks++; if (done_cnt !== 2) $display("FAIL b2b_done_count: got %0d, required 2", done_cnt); else n_pass++;
  endtask

  task automatic test_mid_change();
    int k;
    clear_mon();
    exp_q.push_back(16'h8155);
    exp_q.push_back(16'hFFFF);
    send(7'h01, 8'h55);
    repeat (40) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 7'h7F;
    req_data  = 8'hFF;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_frames(2);
    wait_ready();
    n_checks++; if (frame_q[0] !== exp_q[0]) $display("FAIL mid_bits0: got %h, required %h", frame_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (frame_q[1] !== exp_q[1]) $display("FAIL mid_bits1: got %h, required %h", frame_q[1], exp_q[1]); else n_pass++;
    n_checks++; if (hs_q[1] - hs_q[0] !== PERIOD) $display("FAIL mid_hs_delay: got %0d, required %0d", hs_q[1] - hs_q[0], PERIOD); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    clear_mon();
    send(7'h02, 8'h3C);
    k = 0;
    while (cur_rises < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (ncs !== 1'b1) $display("FAIL rst_mid_ncs: got %b, required 1", ncs); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL rst_mid_sclk: got %b, required 0", sclk); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b, required 1", req_ready); else n_pass++;
    n_checks++; if (copi !== 1'b0) $display("FAIL rst_mid_copi: got %b, required 0", copi); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    exp_q.push_back(16'h835A);
    send(7'h03, 8'h5A);
    wait_frames(1);
    wait_ready();
    n_checks++; if (frame_q[0] !== exp_q[0]) $display("FAIL rst_after_bits: got %h, required %h", frame_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (rise_q[0] !== 16) $display("FAIL rst_after_rises: got %0d, required 16", rise_q[0]); else n_pass++;
    n_checks++; if (low_q[0] !== FRAME_LOW) $display("FAIL rst_after_ncs_low: got %0d, required %0d", low_q[0], FRAME_LOW); else n_pass++;
  endtask

  task automatic test_loopback();
    regs[4] = 8'h00;
    regs[1] = 8'h00;
    clear_mon();
    send(7'h04, 8'h80);
    wait_frames(1);
    send(7'h01, 8'h0F);
    wait_frames(2);
    wait_ready();
    n_checks++; if (regs[4] !== 8'h80) $display("FAIL loop_pwm_duty: got %h, required 80", regs[4]); else n_pass++;
    n_checks++; if (regs[1] !== 8'h0F) $display("FAIL loop_en_hi: got %h, required 0f", regs[1]); else n_pass++;
  endtask

`ifdef SPI_CTRL_ADDR_CHECK_EN
  task automatic test_addr_check();
    clear_mon();
    err_cnt = 0;
    send(7'h05, 8'h11);
    repeat (20) @(negedge clk);
    n_checks++; if (err_cnt !== 1) $display("FAIL chk_err_pulse: got %0d, required 1", err_cnt); else n_pass++;
    n_checks++; if (fall_cnt !== 0) $display("FAIL chk_ncs_falls: got %0d, required 0", fall_cnt); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL chk_done: got %0d, required 0", done_cnt); else n_pass++;
    n_checks++; if (ready_low_cnt !== 1) $display("FAIL chk_ready_low: got %0d, required 1", ready_low_cnt); else n_pass++;
    clear_mon();
    exp_q.push_back(16'h8422);
    send(7'h04, 8'h22);
    wait_frames(1);
    wait_ready();
    n_checks++; if (frame_q[0] !== exp_q[0]) $display("FAIL chk_addr4_bits: got %h, required %h", frame_q[0], exp_q[0]); else n_pass++;
  endtask
`else
  task automatic test_err_quiet();
    n_checks++; if (err_cnt !== 0) $display("FAIL err_quiet: got %0d pulses, required 0", err_cnt); else n_pass++;
  endtask
`endif

  // Sequence and final report
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifndef SPI_CTRL_ADDR_CHECK_EN
    test_mid_change();
`endif
    test_reset_mid_frame();
    test_loopback();
`ifdef SPI_CTRL_ADDR_CHECK_EN
    test_addr_check();
`else
    test_err_quiet();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
